// File: rtl/muldiv_seq.sv
// Sequencer between the control unit and the multicycle mult/div units.
// Latches operands, pulses the selected unit's start, waits with a watchdog, and owns HI/LO.
module muldiv_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] RegAOut,
  input  logic [WIDTH-1:0] RegBOut,
  output logic [WIDTH-1:0] UnitA,
  output logic [WIDTH-1:0] UnitB,
  output logic             MultCtrl,
  input  logic             MultDone,
  input  logic [WIDTH-1:0] MultHI,
  input  logic [WIDTH-1:0] MultLO,
  output logic             DivCtrl,
  input  logic             DivDone,
  input  logic [WIDTH-1:0] DivHI,
  input  logic [WIDTH-1:0] DivLO,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Timeout
);

  localparam int unsigned     TW    = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_t;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_DIV = 2'b01, OP_MTHI = 2'b10, OP_MTLO = 2'b11} op_t;

  state_t           state, state_n;
  op_t              op_q, op_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n, hi_q, hi_n, lo_q, lo_n;
  logic [TW-1:0]    timer_q, timer_n;
  logic             dz_q, dz_n, to_q, to_n;
  logic             sel_done;
  logic [WIDTH-1:0] sel_hi, sel_lo;

  // Only the launched unit's handshake is observed; the other unit's done is ignored.
  always_comb begin
    sel_done = MultDone;
    sel_hi   = MultHI;
    sel_lo   = MultLO;
    if (op_q == OP_DIV) begin
      sel_done = DivDone;
      sel_hi   = DivHI;
      sel_lo   = DivLO;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    timer_n = timer_q;
    dz_n    = 1'b0;
    to_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          op_n = op_t'(Op);
          a_n  = RegAOut;
          b_n  = RegBOut;
          case (op_t'(Op))
            OP_MTHI: begin hi_n = RegAOut; state_n = S_FINISH; end
            OP_MTLO: begin lo_n = RegAOut; state_n = S_FINISH; end
            OP_DIV: begin
              if (RegBOut == '0) begin
                dz_n    = 1'b1;
                state_n = S_FINISH;
              end else begin
                state_n = S_LAUNCH;
              end
            end
            default: state_n = S_LAUNCH;
          endcase
        end
      end
      S_LAUNCH: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A done in the last allowed cycle still wins over the watchdog.
        if (sel_done) begin
          hi_n    = sel_hi;
          lo_n    = sel_lo;
          state_n = S_FINISH;
        end else if (timer_q == TLAST) begin
          to_n    = 1'b1;
          state_n = S_FINISH;
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      timer_q <= '0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      a_q     <= a_n;
      b_q     <= b_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      timer_q <= timer_n;
      dz_q    <= dz_n;
      to_q    <= to_n;
    end
  end

  assign UnitA    = a_q;
  assign UnitB    = b_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign Busy     = (state != S_IDLE);
  assign Done     = (state == S_FINISH);
  assign MultCtrl = (state == S_LAUNCH) && (op_q == OP_MULT);
  assign DivCtrl  = (state == S_LAUNCH) && (op_q == OP_DIV);
  assign DivZero  = dz_q;
  assign Timeout  = to_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: behavioural mult/div stand-ins plus a scoreboard of
// expected HI/LO, flags, latency and start-pulse counts per operation.
module tb_muldiv_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] RegAOut, RegBOut, UnitA, UnitB;
  logic         MultCtrl, MultDone, DivCtrl, DivDone;
  logic [W-1:0] MultHI, MultLO, DivHI, DivLO, HI, LO;
  logic         Busy, Done, DivZero, Timeout;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op),
    .RegAOut(RegAOut), .RegBOut(RegBOut), .UnitA(UnitA), .UnitB(UnitB),
    .MultCtrl(MultCtrl), .MultDone(MultDone), .MultHI(MultHI), .MultLO(MultLO),
    .DivCtrl(DivCtrl), .DivDone(DivDone), .DivHI(DivHI), .DivLO(DivLO),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivZero(DivZero), .Timeout(Timeout)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        tmo;
    int          lat;
    int          mc;
    int          dc;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [63:0] p;

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic [31:0] srem(input logic [31:0] a, input logic [31:0] b);
    return $signed(a) % $signed(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: model the expectation, drive it, emulate the unit, compare on Done.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] rhi, input logic [31:0] rlo,
                       input bit noise, input bit hold);
    exp_t e, g;
    int   cnt, lat, mc, dc;
    bit   got;
    e.dz = 1'b0; e.tmo = 1'b0; e.mc = 0; e.dc = 0; e.lat = 1;
    if (op[1]) begin
      if (op == 2'b10) hi_m = a; else lo_m = a;
    end else if (op == 2'b01 && b == '0) begin
      e.dz = 1'b1;
    end else begin
      if (op == 2'b00) e.mc = 1; else e.dc = 1;
      if (n > 0) begin
        hi_m = rhi; lo_m = rlo; e.lat = 2 + n;
      end else begin
        e.tmo = 1'b1; e.lat = 2 + int'(TO);
      end
    end
    e.hi = hi_m;
    e.lo = lo_m;
    exp_q.push_back(e);

    Start = 1'b1; Op = op; RegAOut = a; RegBOut = b;
    if (op == 2'b00) begin MultHI = rhi; MultLO = rlo; end
    else begin DivHI = rhi; DivLO = rlo; end
    cnt = 0; lat = 0; mc = 0; dc = 0; got = 1'b0;
    while (!got && lat < int'(TO) + 10) begin
      tick();
      lat++;
      if (hold && lat < 3) begin
        Start = 1'b1; Op = 2'b10; RegAOut = 32'hBAD0_BAD0; RegBOut = '0;
      end else begin
        Start = 1'b0;
      end
      MultDone = 1'b0;
      DivDone  = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (op == 2'b00) MultDone = 1'b1; else DivDone = 1'b1;
        end
      end
      if (MultCtrl) mc++;
      if (DivCtrl)  dc++;
      if ((MultCtrl && op == 2'b00) || (DivCtrl && op == 2'b01)) cnt = n;
      if (noise) begin
        if (op == 2'b00) begin DivDone = 1'b1; DivHI = 32'h5A5A_5A5A; DivLO = 32'hA5A5_A5A5; end
        else begin MultDone = 1'b1; MultHI = 32'h5A5A_5A5A; MultLO = 32'hA5A5_A5A5; end
      end
      if (Done) got = 1'b1;
    end
    MultDone = 1'b0;
    DivDone  = 1'b0;
    Start    = 1'b0;
    g = exp_q.pop_front();
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("latency",     32'(lat),     32'(g.lat));
      chk("hi",          HI,           g.hi);
      chk("lo",          LO,           g.lo);
      chk("divzero",     32'(DivZero), 32'(g.dz));
      chk("timeout",     32'(Timeout), 32'(g.tmo));
      chk("mult_pulses", 32'(mc),      32'(g.mc));
      chk("div_pulses",  32'(dc),      32'(g.dc));
      chk("unit_a",      UnitA,        a);
      chk("unit_b",      UnitB,        b);
      chk("busy_finish", 32'(Busy),    32'd1);
    end
    tick();
    chk("done_once",   32'(Done),    32'd0);
    chk("busy_idle",   32'(Busy),    32'd0);
    chk("dz_idle",     32'(DivZero), 32'd0);
    chk("tmo_idle",    32'(Timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b0; Start = 1'b0; Op = '0; RegAOut = '0; RegBOut = '0;
    MultDone = 1'b0; DivDone = 1'b0; MultHI = '0; MultLO = '0; DivHI = '0; DivLO = '0;
    #2;
    chk("rst_hi",   HI, '0);
    chk("rst_lo",   LO, '0);
    chk("rst_ua",   UnitA, '0);
    chk("rst_ctl",  {26'd0, Busy, Done, MultCtrl, DivCtrl, DivZero, Timeout}, '0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    p = mul64(32'd6, 32'd7);
    do_op(2'b00, 32'd6, 32'd7, 3, p[63:32], p[31:0], 1'b0, 1'b0);
    p = mul64(32'hFFFF_FFFB, 32'd3);
    do_op(2'b00, 32'hFFFF_FFFB, 32'd3, 4, p[63:32], p[31:0], 1'b0, 1'b1);
    chk("neg_mult_hi", HI, 32'hFFFF_FFFF);
    chk("neg_mult_lo", LO, 32'hFFFF_FFF1);
    do_op(2'b01, 32'd17, 32'd5, 2, srem(32'd17, 32'd5), sdiv(32'd17, 32'd5), 1'b0, 1'b0);
    chk("div_hi", HI, 32'd2);
    chk("div_lo", LO, 32'd3);
    do_op(2'b01, 32'd7, 32'd0, 2, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFEF, 32'd5, 1, srem(32'hFFFF_FFEF, 32'd5), sdiv(32'hFFFF_FFEF, 32'd5), 1'b0, 1'b0);
    do_op(2'b10, 32'hDEAD_BEEF, 32'd9, 0, '0, '0, 1'b0, 1'b0);
    do_op(2'b11, 32'h1234_5678, 32'd9, 0, '0, '0, 1'b0, 1'b0);
    chk("mt_hi", HI, 32'hDEAD_BEEF);
    chk("mt_lo", LO, 32'h1234_5678);
    do_op(2'b00, 32'd2, 32'd2, 0, 32'hCAFE_0000, 32'h0000_CAFE, 1'b1, 1'b0);
    p = mul64(32'h7FFF_FFFF, 32'd2);
    do_op(2'b00, 32'h7FFF_FFFF, 32'd2, int'(TO), p[63:32], p[31:0], 1'b0, 1'b0);
    do_op(2'b01, 32'd100, 32'd7, 3, srem(32'd100, 32'd7), sdiv(32'd100, 32'd7), 1'b1, 1'b0);

    // Asynchronous reset while waiting on the multiplier.
    Start = 1'b1; Op = 2'b00; RegAOut = 32'd3; RegBOut = 32'd4;
    MultHI = 32'h0; MultLO = 32'd12;
    tick();
    Start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("arst_hi",  HI, '0);
    chk("arst_lo",  LO, '0);
    chk("arst_ub",  UnitB, '0);
    chk("arst_ctl", {26'd0, Busy, Done, MultCtrl, DivCtrl, DivZero, Timeout}, '0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    MultDone = 1'b1;
    tick();
    MultDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_done", 32'(Done), 32'd0);
      chk("late_busy", 32'(Busy), 32'd0);
      tick();
    end
    chk("late_lo", LO, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
